id_stage_pipe: RTL and testbench

//  Pipelined RV32I decode stage between fetch and execute. Buffers fetched instructions in a small FIFO.

---
 rtl/riscv_decode_pkg.sv | 49 ++++
 rtl/id_skid_fifo.sv | 39 +++
 rtl/id_stage_pipe.sv | 168 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// riscv_decode_pkg: RV32I opcodes, immediate selection and the ID->EX bundle
package riscv_decode_pkg;
  localparam int XLEN_D       = 32;
  localparam int RADDR_W_D    = 5;
  localparam int CSR_ADDR_W_D = 12;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_PRIV    = 3'd0;
  localparam logic [2:0] F3_CSR_BAD = 3'd4;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef struct packed {
    logic [XLEN_D-1:0]       op1;
    logic [XLEN_D-1:0]       op2;
    logic [XLEN_D-1:0]       offset;
    logic [31:0]             inst;
    logic [XLEN_D-1:0]       inst_addr;
    logic [XLEN_D-1:0]       reg1_rdata;
    logic [XLEN_D-1:0]       reg2_rdata;
    logic                    reg_wen;
    logic [RADDR_W_D-1:0]    reg_waddr;
    logic                    csr_wen;
    logic [CSR_ADDR_W_D-1:0] csr_waddr;
    logic [XLEN_D-1:0]       csr_rdata;
    logic                    illegal;
  } id_ex_t;
  function automatic imm_sel_e imm_sel(input logic [6:0] opc);
    return (opc == OPC_LOAD || opc == OPC_IMM || opc == OPC_JALR) ? IMM_I :
           (opc == OPC_STORE)                                   ? IMM_S :
           (opc == OPC_BRANCH)                                  ? IMM_B :
           (opc == OPC_LUI || opc == OPC_AUIPC)                 ? IMM_U :
           (opc == OPC_JAL)                                     ? IMM_J : IMM_NONE;
  endfunction
  function automatic logic [XLEN_D-1:0] gen_imm(input logic [31:0] i, input imm_sel_e s);
    return s == IMM_I ? {{20{i[31]}}, i[31:20]} :
           s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           s == IMM_U ? {i[31:12], 12'b0} :
           s == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : '0;
  endfunction
endpackage

// File: rtl/id_skid_fifo.sv
// id_skid_fifo: DEPTH-entry instruction buffer with push/pop/flush and registered ready
// Ports: clk_i, rst_i (async, high), flush_i empties; push_i/data_i write, pop_i/data_o read head;
//        empty_o when no entries; ready_o = !full, registered, 0 during reset.
module id_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ready_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0]   cnt, cnt_nx;
  assign empty_o = cnt == '0;
  assign data_o  = mem[rd];
  assign cnt_nx  = flush_i ? '0 : cnt + (AW+1)'(push_i) - (AW+1)'(pop_i);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr      <= '0;
      rd      <= '0;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else begin
      wr      <= flush_i ? '0 : wr + AW'(push_i);
      rd      <= flush_i ? '0 : rd + AW'(pop_i);
      cnt     <= cnt_nx;
      ready_o <= cnt_nx != (AW+1)'(DEPTH);
    end
  always_ff @(posedge clk_i)
    if (push_i) mem[wr] <= data_i;
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined RV32I decode stage (fetch FIFO -> decode/regfile read -> EX register)
// Ports: fetch in_valid_i/in_ready_o/inst_i/inst_addr_i, flush_i, GPR read reg{1,2}_raddr_o/_rdata_i,
//        CSR read csr_raddr_o/csr_rdata_i, EX out_valid_o/out_ready_i plus the registered bundle.
// Option: define ID_CSR_EN to decode Zicsr; otherwise CSR outputs are 0 and SYSTEM func3!=0 is illegal.
import riscv_decode_pkg::*;
module id_stage_pipe #(
  parameter int XLEN       = XLEN_D,
  parameter int RADDR_W    = RADDR_W_D,
  parameter int CSR_ADDR_W = CSR_ADDR_W_D,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           inst_i,
  input  logic [XLEN-1:0]       inst_addr_i,
  input  logic                  flush_i,
  output logic [RADDR_W-1:0]    reg1_raddr_o,
  output logic [RADDR_W-1:0]    reg2_raddr_o,
  input  logic [XLEN-1:0]       reg1_rdata_i,
  input  logic [XLEN-1:0]       reg2_rdata_i,
  output logic [CSR_ADDR_W-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [XLEN-1:0]       op1_o,
  output logic [XLEN-1:0]       op2_o,
  output logic [XLEN-1:0]       offset_o,
  output logic [31:0]           inst_o,
  output logic [XLEN-1:0]       inst_addr_o,
  output logic [XLEN-1:0]       reg1_rdata_o,
  output logic [XLEN-1:0]       reg2_rdata_o,
  output logic                  reg_wen_o,
  output logic [RADDR_W-1:0]    reg_waddr_o,
  output logic                  csr_wen_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_rdata_o,
  output logic                  illegal_o
);
  logic [32+XLEN-1:0] head;
  logic [31:0]        hi;
  logic [XLEN-1:0]    hpc, imm, op1, op2, off;
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [4:0]         rd, rs1, rs2;
  logic               empty, push, load, stall, legal, use1, use2, wen, csr_op;
  id_ex_t             q, nxt;
  id_skid_fifo #(.DEPTH(BUF_DEPTH), .W(32+XLEN)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  ({inst_i, inst_addr_i}),
    .pop_i   (load),
    .data_o  (head),
    .empty_o (empty),
    .ready_o (in_ready_o)
  );
  assign hi  = head[32+XLEN-1:XLEN];
  assign hpc = head[XLEN-1:0];
  assign opc = hi[6:0];
  assign f3  = hi[14:12];
  assign rd  = hi[11:7];
  assign rs1 = hi[19:15];
  assign rs2 = hi[24:20];
  assign imm = gen_imm(hi, imm_sel(opc));
  assign push = in_valid_i && in_ready_o && !flush_i;
  // Load-use: EX holds a load whose rd the head needs, so the head waits one slot.
  assign stall = out_valid_o && q.reg_wen && q.inst[6:0] == OPC_LOAD &&
                 ((use1 && rs1 == q.reg_waddr) || (use2 && rs2 == q.reg_waddr));
  assign load  = !empty && (!out_valid_o || out_ready_i) && !stall && !flush_i;
  assign reg1_raddr_o = (!empty && use1) ? rs1 : '0;
  assign reg2_raddr_o = (!empty && use2) ? rs2 : '0;
  always_comb begin
    legal  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    wen    = 1'b0;
    csr_op = 1'b0;
    op1    = '0;
    op2    = '0;
    off    = '0;
    case (opc)
      OPC_LUI:    begin legal = 1'b1; wen = 1'b1; op1 = imm; end
      OPC_AUIPC:  begin legal = 1'b1; wen = 1'b1; op1 = hpc; op2 = imm; end
      OPC_JAL:    begin legal = 1'b1; wen = 1'b1; op2 = hpc; off = imm; end
      OPC_JALR:   begin legal = f3 == 3'd0; use1 = 1'b1; wen = 1'b1; op1 = reg1_rdata_i; op2 = hpc; off = imm; end
      OPC_BRANCH: begin legal = f3 != 3'd2 && f3 != 3'd3; use1 = 1'b1; use2 = 1'b1; off = imm; end
      OPC_LOAD:   begin legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; use1 = 1'b1; wen = 1'b1; op1 = reg1_rdata_i; op2 = imm; end
      OPC_STORE:  begin legal = f3 <= 3'd2; use1 = 1'b1; use2 = 1'b1; op1 = reg1_rdata_i; op2 = imm; end
      OPC_IMM:    begin legal = 1'b1; use1 = 1'b1; wen = 1'b1; op1 = reg1_rdata_i; op2 = imm; end
      OPC_OP:     begin legal = 1'b1; use1 = 1'b1; use2 = 1'b1; wen = 1'b1; op1 = reg1_rdata_i; op2 = reg2_rdata_i; end
      OPC_FENCE:  legal = f3 == 3'd0 || f3 == 3'd1;
      OPC_SYSTEM: begin
        legal = f3 == F3_PRIV;
`ifdef ID_CSR_EN
        if (f3 != F3_PRIV && f3 != F3_CSR_BAD) begin
          legal  = 1'b1;
          csr_op = 1'b1;
          wen    = 1'b1;
          use1   = !f3[2];
          // f3[2] selects the zimm form: the rs1 field is the 5-bit immediate itself.
          op1    = f3[2] ? {{(XLEN-5){1'b0}}, rs1} : reg1_rdata_i;
        end
`endif
      end
      default: ;
    endcase
    if (!legal) begin
      use1   = 1'b0;
      use2   = 1'b0;
      wen    = 1'b0;
      csr_op = 1'b0;
      op1    = '0;
      op2    = '0;
      off    = '0;
    end
    wen = wen && rd != 5'd0;
  end
  always_comb begin
    nxt            = '0;
    nxt.op1        = op1;
    nxt.op2        = op2;
    nxt.offset     = off;
    nxt.inst       = hi;
    nxt.inst_addr  = hpc;
    nxt.reg1_rdata = use1 ? reg1_rdata_i : '0;
    nxt.reg2_rdata = use2 ? reg2_rdata_i : '0;
    nxt.reg_wen    = wen;
    nxt.reg_waddr  = wen ? rd : '0;
    nxt.csr_wen    = csr_op;
    nxt.csr_waddr  = csr_op ? hi[31:20] : '0;
    nxt.illegal    = !legal;
`ifdef ID_CSR_EN
    nxt.csr_rdata  = csr_op ? csr_rdata_i : '0;
`endif
  end
`ifdef ID_CSR_EN
  assign csr_raddr_o = (!empty && csr_op) ? hi[31:20] : '0;
`else
  logic unused_csr_rdata;
  assign unused_csr_rdata = ^csr_rdata_i;
  assign csr_raddr_o = '0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      q           <= '0;
      out_valid_o <= 1'b0;
    end else if (flush_i) out_valid_o <= 1'b0;
    else if (load) begin
      q           <= nxt;
      out_valid_o <= 1'b1;
    end else if (out_ready_i) out_valid_o <= 1'b0;
  assign op1_o        = q.op1;
  assign op2_o        = q.op2;
  assign offset_o     = q.offset;
  assign inst_o       = q.inst;
  assign inst_addr_o  = q.inst_addr;
  assign reg1_rdata_o = q.reg1_rdata;
  assign reg2_rdata_o = q.reg2_rdata;
  assign reg_wen_o    = q.reg_wen;
  assign reg_waddr_o  = q.reg_waddr;
  assign csr_wen_o    = q.csr_wen;
  assign csr_waddr_o  = q.csr_waddr;
  assign csr_rdata_o  = q.csr_rdata;
  assign illegal_o    = q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe with directed RV32I vectors
module tb_id_stage_pipe;
  typedef struct packed {
    logic [31:0] inst, pc, op1, op2, off, r1, r2;
    logic        wen;
    logic [4:0]  waddr;
    logic        cwen;
    logic [11:0] caddr;
    logic [31:0] crd;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] inst = '0, inst_addr = '0;
  logic [4:0]  reg1_raddr, reg2_raddr, reg_waddr;
  logic [31:0] reg1_rdata, reg2_rdata, csr_rdata, op1, op2, offset, inst_o, inst_addr_o;
  logic [31:0] reg1_rdata_o, reg2_rdata_o, csr_rdata_o;
  logic [11:0] csr_raddr, csr_waddr;
  logic        reg_wen, csr_wen, illegal;
  int          checks = 0, errors = 0;
  exp_t        sbq[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] rv(input logic [4:0] a);
    return a == 5'd2 ? 32'd5 : {27'd0, a} * 32'h101;
  endfunction
  assign reg1_rdata = rv(reg1_raddr);
  assign reg2_rdata = rv(reg2_raddr);
  assign csr_rdata  = {20'hC5000, csr_raddr};
  id_stage_pipe dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .inst_addr_i(inst_addr), .flush_i(flush),
    .reg1_raddr_o(reg1_raddr), .reg2_raddr_o(reg2_raddr),
    .reg1_rdata_i(reg1_rdata), .reg2_rdata_i(reg2_rdata),
    .csr_raddr_o(csr_raddr), .csr_rdata_i(csr_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op1_o(op1), .op2_o(op2), .offset_o(offset), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .reg1_rdata_o(reg1_rdata_o), .reg2_rdata_o(reg2_rdata_o),
    .reg_wen_o(reg_wen), .reg_waddr_o(reg_waddr),
    .csr_wen_o(csr_wen), .csr_waddr_o(csr_waddr), .csr_rdata_o(csr_rdata_o),
    .illegal_o(illegal)
  );
  function automatic exp_t mk(input logic [31:0] i, pc, o1, o2, of, r1, r2, input logic w,
                              input logic [4:0] wa, input logic cw, input logic [11:0] ca,
                              input logic [31:0] cr, input logic il);
    exp_t e;
    e = '{i, pc, o1, o2, of, r1, r2, w, wa, cw, ca, cr, il};
    return e;
  endfunction
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      exp_t g, e;
      g = {inst_o, inst_addr_o, op1, op2, offset, reg1_rdata_o, reg2_rdata_o, reg_wen, reg_waddr,
           csr_wen, csr_waddr, csr_rdata_o, illegal};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got inst=%h pc=%h, required no output", inst_o, inst_addr_o);
      end else begin
        e = sbq.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL txn pc=%h: got inst=%h op1=%h op2=%h off=%h r1=%h r2=%h wen=%b wa=%0d cwen=%b ca=%h crd=%h ill=%b; required inst=%h op1=%h op2=%h off=%h r1=%h r2=%h wen=%b wa=%0d cwen=%b ca=%h crd=%h ill=%b",
                   e.pc, g.inst, g.op1, g.op2, g.off, g.r1, g.r2, g.wen, g.waddr, g.cwen, g.caddr, g.crd, g.ill,
                   e.inst, e.op1, e.op2, e.off, e.r1, e.r2, e.wen, e.waddr, e.cwen, e.caddr, e.crd, e.ill);
        end
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  task automatic send(input exp_t e, input bit track);
    int n = 0;
    in_valid  = 1'b1;
    inst      = e.inst;
    inst_addr = e.pc;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout pc=%h: in_ready got 0, required 1", e.pc);
      in_valid = 1'b0;
      return;
    end
    if (track) sbq.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sbq.size()), 32'd0);
    tick();
  endtask
  exp_t v_addi, v_lw, v_add, v_jal, v_lui, v_auipc, v_sw, v_beq, v_ill, v_csr, v_jalr, v_fin;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end
  initial begin
    v_addi  = mk(32'hFFF10093, 32'h100, 32'd5, 32'hFFFFFFFF, 0, 32'd5, 0, 1, 1, 0, 0, 0, 0);
    v_lw    = mk(32'h00022183, 32'h104, 32'h404, 0, 0, 32'h404, 0, 1, 3, 0, 0, 0, 0);
    v_add   = mk(32'h006182B3, 32'h108, 32'h303, 32'h606, 0, 32'h303, 32'h606, 1, 5, 0, 0, 0, 0);
    v_jal   = mk(32'h008000EF, 32'h200, 0, 32'h200, 32'd8, 0, 0, 1, 1, 0, 0, 0, 0);
    v_lui   = mk(32'h123453B7, 32'h204, 32'h12345000, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    v_auipc = mk(32'h00001417, 32'h208, 32'h208, 32'h1000, 0, 0, 0, 1, 8, 0, 0, 0, 0);
    v_sw    = mk(32'h00622423, 32'h20C, 32'h404, 32'd8, 0, 32'h404, 32'h606, 0, 0, 0, 0, 0, 0);
    v_beq   = mk(32'hFE000EE3, 32'h300, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0);
    v_ill   = mk(32'h0000007F, 32'h304, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef ID_CSR_EN
    v_csr   = mk(32'h300110F3, 32'h308, 32'd5, 0, 0, 32'd5, 0, 1, 1, 1, 12'h300, 32'hC5000300, 0);
`else
    v_csr   = mk(32'h300110F3, 32'h308, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    v_jalr  = mk(32'h004100E7, 32'h30C, 32'd5, 32'h30C, 32'd4, 32'd5, 0, 1, 1, 0, 0, 0, 0);
    v_fin   = mk(32'hFFF10093, 32'h400, 32'd5, 32'hFFFFFFFF, 0, 32'd5, 0, 1, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 0);
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_op1", op1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("in_ready_after_reset", {31'd0, in_ready}, 1);
    out_ready = 1'b1;
    send(v_addi, 1);
    check("latency_not_yet", {31'd0, out_valid}, 0);
    tick();
    check("latency_n_plus_2", {31'd0, out_valid}, 1);
    send(v_lw, 1);
    send(v_add, 1);
    check("loaduse_lw_out", {out_valid, inst_o[30:0]}, {1'b1, v_lw.inst[30:0]});
    tick();
    check("loaduse_bubble", {31'd0, out_valid}, 0);
    tick();
    check("loaduse_add_out", {out_valid, inst_o[30:0]}, {1'b1, v_add.inst[30:0]});
    drain();
    out_ready = 1'b0;
    send(v_jal, 1);
    send(v_lui, 1);
    send(v_auipc, 1);
    check("full_in_ready", {31'd0, in_ready}, 0);
    check("full_head_out", {out_valid, inst_o[30:0]}, {1'b1, v_jal.inst[30:0]});
    in_valid  = 1'b1;
    inst      = v_sw.inst;
    inst_addr = v_sw.pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_blocks", {31'd0, in_ready}, 0);
      check("hold_stable", op2, v_jal.op2);
    end
    out_ready = 1'b1;
    send(v_sw, 1);
    drain();
    send(v_beq, 1);
    send(v_ill, 1);
    send(v_csr, 1);
    send(v_jalr, 1);
    drain();
    out_ready = 1'b0;
    send(mk(32'hFFF10093, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    send(mk(32'hFFF10093, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    send(mk(32'hFFF10093, 32'h508, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    check("pre_flush_valid", {31'd0, out_valid}, 1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    inst      = 32'h123453B7;
    inst_addr = 32'h50C;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 0);
    check("flush_in_ready", {31'd0, in_ready}, 1);
    flush     = 1'b1;
    in_valid  = 1'b1;
    inst_addr = 32'h510;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        seen += int'(out_valid);
      end
      check("flush_drops_push", 32'(seen), 0);
    end
    send(v_fin, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
